// File: rtl/memory_encoder_writer_pkg.sv
// rtl/memory_encoder_writer_pkg.sv - shared widths and FSM state encoding for the frame-memory write path
package memory_encoder_writer_pkg;

    localparam int R_BITS = 3;
    localparam int G_BITS = 3;
    localparam int B_BITS = 2;
    localparam int CODE_W = 8;
    localparam int RGB_W  = 24;
    localparam int WORD_W = 16;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        HALF  = 2'd1,
        WRITE = 2'd2
    } wr_state_e;

endpackage

// File: rtl/memory_encoder_writer_if.sv
// rtl/memory_encoder_writer_if.sv - pixel input and frame-memory write port bundle
interface memory_encoder_writer_if
    import memory_encoder_writer_pkg::*;
#(
    parameter int ADDR_W = 15
) ();

    logic              PIX_VALID;
    logic              PIX_READY;
    logic [RGB_W-1:0]  PIX_RGB;
    logic              PIX_SOF;
    logic              MEM_WREQ;
    logic              MEM_WACK;
    logic [ADDR_W-1:0] MEM_ADDR;
    logic [WORD_W-1:0] MEM_IN;
    logic              FRAME_DONE;

    // master: pixel source plus memory responder; slave: the encoder/writer
    modport master (
        output PIX_VALID, PIX_RGB, PIX_SOF, MEM_WACK,
        input  PIX_READY, MEM_WREQ, MEM_ADDR, MEM_IN, FRAME_DONE
    );

    modport slave (
        input  PIX_VALID, PIX_RGB, PIX_SOF, MEM_WACK,
        output PIX_READY, MEM_WREQ, MEM_ADDR, MEM_IN, FRAME_DONE
    );

endinterface

// File: rtl/memory_encoder_writer_pixel_encoder.sv
// rtl/memory_encoder_writer_pixel_encoder.sv - RGB888 to RGB332 encoder; MEMORY_ENCODER_ROUND_EN selects rounding
module pixel_encoder
    import memory_encoder_writer_pkg::*;
(
    input  logic [RGB_W-1:0]  rgb_i,
    output logic [CODE_W-1:0] code_o
);

`ifdef MEMORY_ENCODER_ROUND_EN
    logic [8:0]        r_sum;
    logic [8:0]        g_sum;
    logic [8:0]        b_sum;
    logic [R_BITS-1:0] r3;
    logic [G_BITS-1:0] g3;
    logic [B_BITS-1:0] b2;
    logic              unused_sum;

    // bit 8 set means the rounded value overflowed the field, so clamp to all ones
    always_comb begin
        r_sum  = {1'b0, rgb_i[23:16]} + 9'd16;
        g_sum  = {1'b0, rgb_i[15:8]}  + 9'd16;
        b_sum  = {1'b0, rgb_i[7:0]}   + 9'd32;
        r3     = r_sum[8] ? '1 : r_sum[7:5];
        g3     = g_sum[8] ? '1 : g_sum[7:5];
        b2     = b_sum[8] ? '1 : b_sum[7:6];
        code_o = {r3, g3, b2};
    end

    assign unused_sum = ^{r_sum[4:0], g_sum[4:0], b_sum[5:0]};
`else
    logic unused_bits;

    assign code_o      = {rgb_i[23:21], rgb_i[15:13], rgb_i[7:6]};
    assign unused_bits = ^{rgb_i[20:16], rgb_i[12:8], rgb_i[5:0]};
`endif

endmodule

// File: rtl/memory_encoder_writer.sv
// rtl/memory_encoder_writer.sv - packs two RGB332 codes per word and writes them sequentially to frame memory
module memory_encoder_writer
    import memory_encoder_writer_pkg::*;
#(
    parameter int ADDR_W      = 15,
    parameter int FRAME_WORDS = 9600
) (
    input  logic                    CLK,
    input  logic                    RST_N,
    memory_encoder_writer_if.slave  bus
);

    if (FRAME_WORDS < 1 || FRAME_WORDS > (1 << ADDR_W)) begin : g_bad_frame_words
        $error("memory_encoder_writer: FRAME_WORDS must be in 1..2**ADDR_W");
    end

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_WORDS - 1);

    wr_state_e         state_q, state_d;
    logic [WORD_W-1:0] mem_in_q, mem_in_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              frame_done_q, frame_done_d;
    logic [CODE_W-1:0] code;
    logic              accept;
    logic              last_word;

    pixel_encoder u_pixel_encoder (
        .rgb_i  (bus.PIX_RGB),
        .code_o (code)
    );

    assign accept    = bus.PIX_VALID && (state_q != WRITE);
    assign last_word = (addr_q == LAST_ADDR);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q      <= EMPTY;
            mem_in_q     <= '0;
            addr_q       <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            mem_in_q     <= mem_in_d;
            addr_q       <= addr_d;
            frame_done_q <= frame_done_d;
        end
    end

    // SOF in HALF restarts the pair, so it stays in HALF rather than writing
    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY: if (accept) state_d = HALF;
            HALF:  if (accept && !bus.PIX_SOF) state_d = WRITE;
            WRITE: if (bus.MEM_WACK) state_d = EMPTY;
            default: state_d = EMPTY;
        endcase
    end

    always_comb begin
        mem_in_d       = mem_in_q;
        addr_d         = addr_q;
        frame_done_d   = 1'b0;
        bus.PIX_READY  = (state_q != WRITE);
        bus.MEM_WREQ   = (state_q == WRITE);
        bus.MEM_ADDR   = addr_q;
        bus.MEM_IN     = mem_in_q;
        bus.FRAME_DONE = frame_done_q;
        if (accept) begin
            if (state_q == EMPTY || bus.PIX_SOF) begin
                mem_in_d[15:8] = code;
            end else begin
                mem_in_d[7:0] = code;
            end
            if (bus.PIX_SOF) begin
                addr_d = '0;
            end
        end
        if (state_q == WRITE && bus.MEM_WACK) begin
            frame_done_d = last_word;
            addr_d       = last_word ? '0 : addr_q + ADDR_W'(1);
        end
    end

endmodule

// File: tb/tb_memory_encoder_writer.sv
// tb/tb_memory_encoder_writer.sv - randomized and directed bench for memory_encoder_writer
module tb_memory_encoder_writer;
    import memory_encoder_writer_pkg::*;

    localparam int ADDR_W      = 15;
    localparam int FRAME_WORDS = 9600;

    logic CLK   = 1'b0;
    logic RST_N = 1'b0;
    always #5 CLK = ~CLK;

    memory_encoder_writer_if #(.ADDR_W(ADDR_W)) bus ();

    memory_encoder_writer #(
        .ADDR_W      (ADDR_W),
        .FRAME_WORDS (FRAME_WORDS)
    ) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (bus)
    );

    int         vectors     = 0;
    int         miscompares = 0;
    int         exp_addr    = 0;
    int         done_pulses = 0;
    logic       tie_wack    = 1'b0;
    logic [7:0] pend[$];

    function automatic logic [7:0] ref_code(logic [23:0] rgb);
        int r = int'(rgb[23:16]);
        int g = int'(rgb[15:8]);
        int b = int'(rgb[7:0]);
        int r3, g3, b2;
`ifdef MEMORY_ENCODER_ROUND_EN
        r3 = (r + 16) / 32; if (r3 > 7) r3 = 7;
        g3 = (g + 16) / 32; if (g3 > 7) g3 = 7;
        b2 = (b + 32) / 64; if (b2 > 3) b2 = 3;
`else
        r3 = r / 32;
        g3 = g / 32;
        b2 = b / 64;
`endif
        return 8'(r3 * 32 + g3 * 4 + b2);
    endfunction

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push(logic [23:0] rgb, logic sof);
        int n = 0;
        while (bus.PIX_READY !== 1'b1 && n < 20) begin
            @(negedge CLK);
            n++;
        end
        check("ready_before_push", 32'(bus.PIX_READY), 32'd1);
        bus.PIX_VALID = 1'b1;
        bus.PIX_RGB   = rgb;
        bus.PIX_SOF   = sof;
        @(negedge CLK);
        bus.PIX_VALID = 1'b0;
        bus.PIX_SOF   = 1'b0;
        if (sof) begin
            pend.delete();
            exp_addr = 0;
        end
        pend.push_back(ref_code(rgb));
        check("frame_done_idle", 32'(bus.FRAME_DONE), 32'd0);
    endtask

    task automatic write_word(int hold);
        logic [15:0] word;
        word = (pend.size() == 2) ? {pend[0], pend[1]} : 16'hxxxx;
        for (int i = 0; i < hold; i++) begin
            check("wreq_high", 32'(bus.MEM_WREQ), 32'd1);
            check("ready_low", 32'(bus.PIX_READY), 32'd0);
            check("mem_addr", 32'(bus.MEM_ADDR), 32'(exp_addr));
            check("mem_in", 32'(bus.MEM_IN), 32'(word));
            if (i < hold - 1) @(negedge CLK);
        end
        bus.MEM_WACK = 1'b1;
        @(negedge CLK);
        bus.MEM_WACK = tie_wack;
        check("wreq_low_after_ack", 32'(bus.MEM_WREQ), 32'd0);
        check("ready_after_ack", 32'(bus.PIX_READY), 32'd1);
        check("frame_done", 32'(bus.FRAME_DONE), 32'(exp_addr == FRAME_WORDS - 1));
        if (bus.FRAME_DONE === 1'b1) done_pulses++;
        exp_addr = (exp_addr + 1) % FRAME_WORDS;
        pend.delete();
        check("addr_after_ack", 32'(bus.MEM_ADDR), 32'(exp_addr));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.PIX_VALID = 1'b0;
        bus.PIX_RGB   = '0;
        bus.PIX_SOF   = 1'b0;
        bus.MEM_WACK  = 1'b0;
        repeat (2) @(negedge CLK);
        check("rst_ready", 32'(bus.PIX_READY), 32'd1);
        check("rst_wreq", 32'(bus.MEM_WREQ), 32'd0);
        check("rst_addr", 32'(bus.MEM_ADDR), 32'd0);
        check("rst_in", 32'(bus.MEM_IN), 32'd0);
        check("rst_done", 32'(bus.FRAME_DONE), 32'd0);
        RST_N = 1'b1;
        @(negedge CLK);

        push(24'hFF8040, 1'b0);
        push(24'h000000, 1'b0);
        check("first_word", 32'(bus.MEM_IN), 32'h0000F100);
        write_word(3);
        check("addr_one", 32'(bus.MEM_ADDR), 32'd1);

        push(24'($urandom), 1'b0);
        push(24'($urandom), 1'b0);
        bus.PIX_VALID = 1'b1;
        bus.PIX_RGB   = 24'h123456;
        bus.PIX_SOF   = 1'b1;
        write_word(10);
        bus.PIX_VALID = 1'b0;
        bus.PIX_SOF   = 1'b0;

        push(24'h101010, 1'b0);
        push(24'hFFFFFF, 1'b0);
`ifdef MEMORY_ENCODER_ROUND_EN
        check("code_101010", 32'(bus.MEM_IN[15:8]), 32'h24);
`else
        check("code_101010", 32'(bus.MEM_IN[15:8]), 32'h00);
`endif
        check("code_ffffff", 32'(bus.MEM_IN[7:0]), 32'hFF);
        write_word(1);

        for (int k = 0; k < 20; k++) begin
            push(24'($urandom), 1'b0);
            push(24'($urandom), 1'b0);
            write_word(int'($urandom_range(1, 4)));
        end

        push(24'($urandom), 1'b0);
        push(24'($urandom), 1'b1);
        push(24'($urandom), 1'b0);
        check("sof_half_addr", 32'(bus.MEM_ADDR), 32'd0);
        write_word(2);
        push(24'($urandom), 1'b0);
        push(24'($urandom), 1'b0);
        write_word(1);
        push(24'($urandom), 1'b1);
        push(24'($urandom), 1'b0);
        check("sof_empty_addr", 32'(bus.MEM_ADDR), 32'd0);
        write_word(1);

        tie_wack     = 1'b1;
        bus.MEM_WACK = 1'b1;
        done_pulses  = 0;
        for (int w = 0; w <= FRAME_WORDS; w++) begin
            push(24'($urandom), w == 0);
            push(24'($urandom), 1'b0);
            write_word(1);
        end
        tie_wack     = 1'b0;
        bus.MEM_WACK = 1'b0;
        check("frame_done_count", 32'(done_pulses), 32'd1);
        check("addr_after_wrap", 32'(bus.MEM_ADDR), 32'd1);

        push(24'($urandom), 1'b0);
        push(24'($urandom), 1'b0);
        check("pre_reset_wreq", 32'(bus.MEM_WREQ), 32'd1);
        #1 RST_N = 1'b0;
        #1;
        check("async_wreq_drop", 32'(bus.MEM_WREQ), 32'd0);
        check("async_addr", 32'(bus.MEM_ADDR), 32'd0);
        check("async_in", 32'(bus.MEM_IN), 32'd0);
        check("async_ready", 32'(bus.PIX_READY), 32'd1);
        @(negedge CLK);
        RST_N = 1'b1;
        pend.delete();
        exp_addr = 0;
        @(negedge CLK);
        push(24'($urandom), 1'b0);
        push(24'($urandom), 1'b0);
        write_word(2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
